// File: rtl/axis_pkt_m_if.sv
// axis_pkt_m_if: AXI4-Stream master-side bundle used by axis_pkt_m.
// Ports/signals:
//   m_axis_tdata  [WIDTH] stream data (master -> slave)
//   m_axis_tvalid          stream valid (master -> slave)
//   m_axis_tlast           last beat of packet (master -> slave)
//   m_axis_tready          downstream ready (slave -> master)
interface axis_pkt_m_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] m_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tlast;
    logic             m_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/axis_pkt_m.sv
// axis_pkt_m: packetising AXI4-Stream master.
// Upstream words are buffered in a DEPTH-entry first-word-fall-through FIFO;
// packet lengths are buffered in a CFG_DEPTH-entry queue. Beats are emitted
// only while both a word and a length are present, and tlast marks the beat
// whose index matches the head length (0 encodes 2^LEN_WIDTH).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   m_axis          master modport: tdata/tvalid/tlast out, tready in
//   ready/valid_in/data_in            upstream data pop interface
//   config_valid/config_ready/config_len  packet length push interface
//   busy            length queue non-empty
//   pkt_done        one-cycle pulse the cycle after each tlast transfer
module axis_pkt_m #(
    parameter int WIDTH     = 32,
    parameter int LEN_WIDTH = 10,
    parameter int DEPTH     = 4,
    parameter int CFG_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    axis_pkt_m_if.master         m_axis,
    output logic                 ready,
    input  logic                 valid_in,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 config_valid,
    output logic                 config_ready,
    input  logic [LEN_WIDTH-1:0] config_len,
    output logic                 busy,
    output logic                 pkt_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CFG_DEPTH);
    localparam int BW = LEN_WIDTH + 1;

    localparam logic [AW:0]    DATA_FULL  = (AW+1)'(DEPTH);
    localparam logic [CW:0]    CFG_FULL   = (CW+1)'(CFG_DEPTH);
    localparam logic [BW-1:0]  BEAT_FIRST = BW'(1);

    // Data FIFO state
    logic [WIDTH-1:0] data_mem_q [DEPTH];
    logic [AW-1:0]    data_wr_q, data_rd_q;
    logic [AW:0]      data_cnt_q, data_cnt_d;

    // Length queue state
    logic [LEN_WIDTH-1:0] cfg_mem_q [CFG_DEPTH];
    logic [CW-1:0]        cfg_wr_q, cfg_rd_q;
    logic [CW:0]          cfg_cnt_q, cfg_cnt_d;

    // Beat position within the current packet (1-based)
    logic [BW-1:0] beat_q, beat_d;
    logic          pkt_done_q;

    logic                 data_empty_s, data_full_s, cfg_empty_s, cfg_full_s;
    logic [LEN_WIDTH-1:0] cfg_head_s;
    logic [BW-1:0]        target_s;
    logic                 tvalid_s, tlast_s, xfer_s, ready_s;
    logic                 push_s, cfg_push_s, cfg_pop_s;

    // Handshake decode, tlast compare and next-state counts
    always_comb begin
        data_empty_s = (data_cnt_q == (AW+1)'(0));
        data_full_s  = (data_cnt_q == DATA_FULL);
        cfg_empty_s  = (cfg_cnt_q == (CW+1)'(0));
        cfg_full_s   = (cfg_cnt_q == CFG_FULL);
        cfg_head_s   = cfg_mem_q[cfg_rd_q];

        // A zero length field stands for the full 2^LEN_WIDTH beats
        if (cfg_head_s == LEN_WIDTH'(0)) begin
            target_s = {1'b1, {LEN_WIDTH{1'b0}}};
        end else begin
            target_s = {1'b0, cfg_head_s};
        end

        tvalid_s   = !data_empty_s && !cfg_empty_s;
        tlast_s    = tvalid_s && (beat_q == target_s);
        xfer_s     = tvalid_s && m_axis.m_axis_tready;
        // A pop this cycle frees a slot, so a full FIFO can still accept
        ready_s    = !data_full_s || xfer_s;
        push_s     = valid_in && ready_s;
        cfg_push_s = config_valid && !cfg_full_s;
        cfg_pop_s  = xfer_s && tlast_s;

        case ({push_s, xfer_s})
            2'b10:   data_cnt_d = data_cnt_q + (AW+1)'(1);
            2'b01:   data_cnt_d = data_cnt_q - (AW+1)'(1);
            default: data_cnt_d = data_cnt_q;
        endcase

        case ({cfg_push_s, cfg_pop_s})
            2'b10:   cfg_cnt_d = cfg_cnt_q + (CW+1)'(1);
            2'b01:   cfg_cnt_d = cfg_cnt_q - (CW+1)'(1);
            default: cfg_cnt_d = cfg_cnt_q;
        endcase

        if (xfer_s && tlast_s) begin
            beat_d = BEAT_FIRST;
        end else if (xfer_s) begin
            beat_d = beat_q + BW'(1);
        end else begin
            beat_d = beat_q;
        end
    end

    // Storage arrays: written on accepted pushes, contents need no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            data_mem_q[data_wr_q] <= data_in;
        end
        if (cfg_push_s) begin
            cfg_mem_q[cfg_wr_q] <= config_len;
        end
    end

    // Pointers, occupancy counts, beat counter and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            data_wr_q  <= AW'(0);
            data_rd_q  <= AW'(0);
            data_cnt_q <= (AW+1)'(0);
            cfg_wr_q   <= CW'(0);
            cfg_rd_q   <= CW'(0);
            cfg_cnt_q  <= (CW+1)'(0);
            beat_q     <= BEAT_FIRST;
            pkt_done_q <= 1'b0;
        end else begin
            if (push_s) begin
                data_wr_q <= data_wr_q + AW'(1);
            end
            if (xfer_s) begin
                data_rd_q <= data_rd_q + AW'(1);
            end
            if (cfg_push_s) begin
                cfg_wr_q <= cfg_wr_q + CW'(1);
            end
            if (cfg_pop_s) begin
                cfg_rd_q <= cfg_rd_q + CW'(1);
            end
            data_cnt_q <= data_cnt_d;
            cfg_cnt_q  <= cfg_cnt_d;
            beat_q     <= beat_d;
            pkt_done_q <= cfg_pop_s;
        end
    end

    assign m_axis.m_axis_tdata  = data_mem_q[data_rd_q];
    assign m_axis.m_axis_tvalid = tvalid_s;
    assign m_axis.m_axis_tlast  = tlast_s;
    assign ready                = ready_s;
    assign config_ready         = !cfg_full_s;
    assign busy                 = !cfg_empty_s;
    assign pkt_done             = pkt_done_q;
endmodule
